uart_tx_mmio: RTL and testbench
===============================

# uart_tx_mmio

Memory-mapped UART transmitter that sits directly downstream of the multi-cycle RISC-V core. It consumes the core's 32-bit GPIO output word and 2-bit UART register select, queues bytes, and serialises them as 8N1 frames on a single TX line. It also returns a status word the core reads back through its GPIO input.

## Interface
Parameters:
- CLK_FREQ, 50000000, core clock frequency in Hz
- BAUD, 115200, line rate in bit/s; CLKS_PER_BIT = CLK_FREQ/BAUD (truncating integer division, must be ≥ 2)
- FIFO_DEPTH, 4, TX queue entries (power of two, ≥ 2); used only with UART_TX_FIFO_EN

Ports:
- clk  in  1  core clock, all state on rising edge
- reset  in  1  asynchronous, active-low reset
- Reg_Sel  in  2  register select from core: 00 none, 01 TXDATA, 10 STATUS, 11 CONTROL
- Data_In  in  32  core GPIO output word
- Write_En  in  1  write strobe level from core; action on its rising edge only
- Data_Out  out  32  STATUS word when Reg_Sel==10, else 0 (combinational from registered state)
- tx  out  1  serial line, idle high, registered
- tx_busy  out  1  1 while FSM is outside IDLE

## Operation
- Edge detect: register we_d <= Write_En; write event = Write_En & ~we_d. A held level produces exactly one event.
- Write event with Reg_Sel==01: push Data_In[7:0]. If queue full, drop byte and set sticky overrun.
- Write event with Reg_Sel==11: Data_In[0]==1 clears overrun; other bits ignored.
- Write event with Reg_Sel==00 or 10: no effect.
- STATUS: bit0 tx_busy, bit1 full, bit2 empty, bit3 overrun, bits[31:4]=0.
- FSM states: IDLE, START, DATA, STOP.
  - IDLE: tx=1. Queue not empty → pop into 8-bit shift reg, bit index=0, baud counter=CLKS_PER_BIT-1, go START.
  - START: tx=0 for CLKS_PER_BIT cycles → DATA.
  - DATA: tx=shift[0], LSB first. Each bit lasts CLKS_PER_BIT cycles; shift right; after bit 7 → STOP.
  - STOP: tx=1 for CLKS_PER_BIT cycles. Then queue not empty → pop and go straight to START (no idle gap); else → IDLE.
- Baud counter counts down to 0, reloads CLKS_PER_BIT-1 on each bit boundary.
- Same-cycle push and pop: both take effect. On a full queue the pop frees the slot and the push is accepted with no overrun. On an empty queue the FSM does not see the pushed byte until the next cycle.
- Pointers wrap modulo FIFO_DEPTH. Count width is log2(FIFO_DEPTH)+1 so full and empty are distinct.

## Timing
- Reset values (asserted asynchronously): tx=1, tx_busy=0, FSM=IDLE, queue empty, overrun=0, we_d=0. Data_Out=0x0000_0004 when Reg_Sel==10.
- Latency: write event sampled at edge k → START entered and tx=0 after edge k+1.
- Frame length: exactly 10·CLKS_PER_BIT cycles. Back-to-back frames are contiguous.
- Status bits update on the edge after the causing event.
- Reset mid-frame: tx returns high immediately, the in-flight byte and queued bytes are discarded, and no partial frame resumes.

## Configuration
- UART_TX_FIFO_EN defined: queue is a FIFO_DEPTH-entry circular buffer.
- Undefined: queue is a single holding register. full = holding valid, empty = ~full, FIFO_DEPTH is ignored. One byte may be held while another shifts out. All other behaviour is identical.

## Test plan
(CLK_FREQ=1000000, BAUD=100000 → CLKS_PER_BIT=10)
- Reset then Reg_Sel=10 → Data_Out=0x4, tx=1, tx_busy=0.
- Write 0xA5 to TXDATA → tx low one cycle after the write edge, then bits 1,0,1,0,0,1,0,1 (10 cycles each), then stop high; frame is 100 cycles; tx_busy drops after the stop bit.
- Hold Write_En high 20 cycles with Reg_Sel=01, Data_In=0x41 → exactly one frame is sent.
- FIFO on: 6 rapid writes 0x01..0x06 while the first is shifting → 0x01..0x05 sent back-to-back (500 cycles, no idle gap), 0x06 dropped, STATUS bit3=1. A CONTROL write with Data_In=1 clears bit3.
- FIFO off: 3 rapid writes → 2 frames sent, overrun set.
- Assert reset at cycle 40 of a frame → tx=1 immediately; after release STATUS=0x4 and no further frames are sent.

Source files
------------

// File: rtl/uart_tx_mmio.sv
// uart_tx_mmio: memory-mapped 8N1 UART transmitter with a status readback word.
// Define UART_TX_FIFO_EN for a FIFO_DEPTH-entry TX queue; otherwise a single holding register.
module uart_tx_mmio #(
  parameter int unsigned CLK_FREQ   = 50000000,
  parameter int unsigned BAUD       = 115200,
  parameter int unsigned FIFO_DEPTH = 4
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [1:0]  Reg_Sel,
  input  logic [31:0] Data_In,
  input  logic        Write_En,
  output logic [31:0] Data_Out,
  output logic        tx,
  output logic        tx_busy
);

  localparam int unsigned CLKS_PER_BIT = CLK_FREQ / BAUD;
  localparam int unsigned CNT_W        = $clog2(CLKS_PER_BIT);
  localparam logic [CNT_W-1:0] CNT_RELOAD = CNT_W'(CLKS_PER_BIT - 1);

  localparam logic [1:0] REG_TXDATA  = 2'b01;
  localparam logic [1:0] REG_STATUS  = 2'b10;
  localparam logic [1:0] REG_CONTROL = 2'b11;

  typedef enum logic [1:0] {S_IDLE, S_START, S_DATA, S_STOP} state_t;

  state_t           state, state_n;
  logic [CNT_W-1:0] cnt, cnt_n;
  logic [2:0]       bit_idx, bit_n;
  logic [7:0]       shift, shift_n;
  logic             tx_n, busy_n;
  logic             pop;

  logic       we_d;
  logic       push_req, push_ok, clr_ovr;
  logic       overrun;
  logic       q_full, q_empty;
  logic [7:0] q_head;

  // Write strobe rising-edge detection
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) we_d <= 1'b0;
    else        we_d <= Write_En;
  end

  assign push_req = Write_En & ~we_d & (Reg_Sel == REG_TXDATA);
  assign clr_ovr  = Write_En & ~we_d & (Reg_Sel == REG_CONTROL) & Data_In[0];
  // A pop in the same cycle frees a slot, so a push into a full queue still lands
  assign push_ok  = push_req & (~q_full | pop);

  always_ff @(posedge clk or negedge reset) begin
    if (!reset)                          overrun <= 1'b0;
    else if (push_req && q_full && !pop) overrun <= 1'b1;
    else if (clr_ovr)                    overrun <= 1'b0;
  end

`ifdef UART_TX_FIFO_EN
  localparam int unsigned ADDR_W = $clog2(FIFO_DEPTH);
  localparam int unsigned CNTQ_W = ADDR_W + 1;

  logic [7:0]        mem [FIFO_DEPTH];
  logic [ADDR_W-1:0] wr_ptr, rd_ptr;
  logic [CNTQ_W-1:0] count;

  // Circular buffer pointers and occupancy
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push_ok) wr_ptr <= wr_ptr + ADDR_W'(1);
      if (pop)     rd_ptr <= rd_ptr + ADDR_W'(1);
      case ({push_ok, pop})
        2'b10:   count <= count + CNTQ_W'(1);
        2'b01:   count <= count - CNTQ_W'(1);
        default: count <= count;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (push_ok) mem[wr_ptr] <= Data_In[7:0];
  end

  assign q_full  = (count == CNTQ_W'(FIFO_DEPTH));
  assign q_empty = (count == '0);
  assign q_head  = mem[rd_ptr];

  logic unused_ok;
  assign unused_ok = ^Data_In[31:8];
`else
  logic       hold_v;
  logic [7:0] hold_q;

  // Single holding register; a push alongside a pop replaces the popped byte
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      hold_v <= 1'b0;
      hold_q <= '0;
    end else if (push_ok) begin
      hold_v <= 1'b1;
      hold_q <= Data_In[7:0];
    end else if (pop) begin
      hold_v <= 1'b0;
    end
  end

  assign q_full  = hold_v;
  assign q_empty = ~hold_v;
  assign q_head  = hold_q;

  logic unused_ok;
  assign unused_ok = ^{Data_In[31:8], FIFO_DEPTH};
`endif

  // FSM and datapath state register
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state   <= S_IDLE;
      cnt     <= '0;
      bit_idx <= '0;
      shift   <= '0;
      tx      <= 1'b1;
      tx_busy <= 1'b0;
    end else begin
      state   <= state_n;
      cnt     <= cnt_n;
      bit_idx <= bit_n;
      shift   <= shift_n;
      tx      <= tx_n;
      tx_busy <= busy_n;
    end
  end

  // Next-state, pop request and registered-output next values
  always_comb begin
    state_n = state;
    cnt_n   = cnt;
    bit_n   = bit_idx;
    shift_n = shift;
    pop     = 1'b0;

    case (state)
      S_IDLE: begin
        if (!q_empty) begin
          pop     = 1'b1;
          shift_n = q_head;
          bit_n   = '0;
          cnt_n   = CNT_RELOAD;
          state_n = S_START;
        end
      end
      S_START: begin
        if (cnt == '0) begin
          cnt_n   = CNT_RELOAD;
          state_n = S_DATA;
        end else begin
          cnt_n = cnt - CNT_W'(1);
        end
      end
      S_DATA: begin
        if (cnt == '0) begin
          cnt_n = CNT_RELOAD;
          if (bit_idx == 3'd7) begin
            state_n = S_STOP;
          end else begin
            shift_n = shift >> 1;
            bit_n   = bit_idx + 3'd1;
          end
        end else begin
          cnt_n = cnt - CNT_W'(1);
        end
      end
      S_STOP: begin
        if (cnt == '0) begin
          if (!q_empty) begin
            pop     = 1'b1;
            shift_n = q_head;
            bit_n   = '0;
            cnt_n   = CNT_RELOAD;
            state_n = S_START;
          end else begin
            state_n = S_IDLE;
          end
        end else begin
          cnt_n = cnt - CNT_W'(1);
        end
      end
      default: state_n = S_IDLE;
    endcase

    case (state_n)
      S_START: tx_n = 1'b0;
      S_DATA:  tx_n = shift_n[0];
      default: tx_n = 1'b1;
    endcase
    busy_n = (state_n != S_IDLE);
  end

  assign Data_Out = (Reg_Sel == REG_STATUS) ?
                    {28'd0, overrun, q_empty, q_full, tx_busy} : 32'd0;

endmodule

// File: tb/tb_uart_tx_mmio.sv
// tb_uart_tx_mmio: directed and randomized checks of uart_tx_mmio against a
// frame-timing reference model and an independent serial-line decoder.
module tb_uart_tx_mmio;

  localparam int CPB   = 10;
  localparam int FRAME = 10 * CPB;
`ifdef UART_TX_FIFO_EN
  localparam int DEPTH = 4;
`else
  localparam int DEPTH = 1;
`endif

  logic        clk = 1'b0;
  logic        reset;
  logic [1:0]  Reg_Sel;
  logic [31:0] Data_In;
  logic        Write_En;
  logic [31:0] Data_Out;
  logic        tx;
  logic        tx_busy;

  uart_tx_mmio #(
    .CLK_FREQ  (1000000),
    .BAUD      (100000),
    .FIFO_DEPTH(4)
  ) dut (
    .clk     (clk),
    .reset   (reset),
    .Reg_Sel (Reg_Sel),
    .Data_In (Data_In),
    .Write_En(Write_En),
    .Data_Out(Data_Out),
    .tx      (tx),
    .tx_busy (tx_busy)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_pass   = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) $display("FAIL %s: got %h expected %h (t=%0t)", tag, got, exp, $time);
    else             n_pass++;
  endtask

  // Reference model: byte queue plus start cycle of the frame on the line
  logic [7:0] mq[$];
  logic [7:0] sent_q[$];
  logic [7:0] rx_log[$];
  logic       m_we, m_ovr, m_ev;
  logic [7:0] m_fbyte;
  int         m_fstart, cyc, off, slot;
  logic       exp_tx, exp_busy;
  logic [31:0] exp_do;

  initial begin
    cyc = 0; m_fstart = -1000; m_we = 1'b0; m_ovr = 1'b0; m_fbyte = '0;
  end

  always @(posedge clk) begin
    if (!reset) begin
      mq.delete(); sent_q.delete();
      m_we = 1'b0; m_ovr = 1'b0; m_fstart = -1000;
    end else begin
      m_ev = Write_En && !m_we;
      m_we = Write_En;
      if (mq.size() > 0 && cyc >= m_fstart + FRAME) begin
        m_fbyte  = mq.pop_front();
        m_fstart = cyc;
        sent_q.push_back(m_fbyte);
      end
      if (m_ev && Reg_Sel == 2'b01) begin
        if (mq.size() < DEPTH) mq.push_back(Data_In[7:0]);
        else                   m_ovr = 1'b1;
      end
      if (m_ev && Reg_Sel == 2'b11 && Data_In[0]) m_ovr = 1'b0;
    end
    #1;
    off      = cyc - m_fstart;
    exp_busy = (off >= 0 && off < FRAME);
    exp_tx   = 1'b1;
    if (exp_busy) begin
      slot = off / CPB;
      if (slot == 0)      exp_tx = 1'b0;
      else if (slot <= 8) exp_tx = m_fbyte[slot-1];
    end
    exp_do = (Reg_Sel == 2'b10) ?
             {28'd0, m_ovr, mq.size() == 0, mq.size() == DEPTH, exp_busy} : 32'd0;
    check("tx_line", tx, exp_tx);
    check("tx_busy", tx_busy, exp_busy);
    check("data_out", Data_Out, exp_do);
    cyc++;
  end

  // Independent line decoder: samples mid-bit after detecting a start bit
  logic       d_act = 1'b0;
  int         d_off;
  logic [7:0] d_byte;

  always @(posedge clk) begin
    #2;
    if (!reset) begin
      d_act = 1'b0;
    end else if (!d_act) begin
      if (tx === 1'b0) begin
        d_act = 1'b1; d_off = 0; d_byte = '0;
      end
    end else begin
      d_off++;
      if (d_off == 5) check("start_bit", tx, 1'b0);
      if (d_off % CPB == 5 && d_off > CPB && d_off < 9 * CPB) d_byte[d_off/CPB-1] = tx;
      if (d_off == 9 * CPB + 5) begin
        check("stop_bit", tx, 1'b1);
        rx_log.push_back(d_byte);
        if (sent_q.size() > 0) check("rx_byte", d_byte, sent_q.pop_front());
        else                   check("rx_unexpected_frame", 1, 0);
      end
      if (d_off == FRAME - 1) d_act = 1'b0;
    end
  end

  task automatic mmio_write(input logic [1:0] sel, input logic [31:0] data, input int hold);
    @(negedge clk);
    Reg_Sel = sel; Data_In = data; Write_En = 1'b1;
    repeat (hold) @(negedge clk);
    Write_En = 1'b0;
  endtask

  task automatic wait_idle(input int max_cycles);
    int quiet = 0;
    int n = 0;
    while (quiet < 3 && n < max_cycles) begin
      @(negedge clk);
      n++;
      quiet = tx_busy ? 0 : quiet + 1;
    end
    if (quiet < 3) check("wait_idle_timeout", 1, 0);
  endtask

  logic [7:0] exp_burst[$];

  initial begin
    int guard, bc;
    reset = 1'b0; Write_En = 1'b0; Reg_Sel = 2'b00; Data_In = '0;
    repeat (3) @(negedge clk);
    reset = 1'b1;

    // Reset state
    Reg_Sel = 2'b10;
    #1;
    check("rst_status", Data_Out, 32'h4);
    check("rst_tx", tx, 1'b1);
    check("rst_busy", tx_busy, 1'b0);

    // Single 0xA5 frame: latency and length
    rx_log.delete();
    mmio_write(2'b01, 32'h0000_00A5, 1);
    guard = 0; bc = 0;
    while (!tx_busy && guard < 20) begin @(negedge clk); guard++; end
    check("a5_start_latency", guard, 1);
    check("a5_tx_low", tx, 1'b0);
    while (tx_busy && guard < 400) begin bc++; @(negedge clk); guard++; end
    check("a5_frame_len", bc, FRAME);
    wait_idle(50);
    check("a5_rx_count", rx_log.size(), 1);
    if (rx_log.size() > 0) check("a5_rx_byte", rx_log[0], 8'hA5);

    // Held Write_En: one event only
    rx_log.delete();
    mmio_write(2'b01, 32'h0000_0041, 20);
    wait_idle(400);
    check("hold_rx_count", rx_log.size(), 1);
    if (rx_log.size() > 0) check("hold_rx_byte", rx_log[0], 8'h41);

    // Burst of six writes while the first shifts out
    rx_log.delete();
    for (int i = 1; i <= 6; i++) mmio_write(2'b01, 32'(i), 1);
    exp_burst.delete();
    for (int i = 1; i <= DEPTH + 1; i++) exp_burst.push_back(8'(i));
    wait_idle(1000);
    check("burst_rx_count", rx_log.size(), exp_burst.size());
    for (int i = 0; i < rx_log.size() && i < exp_burst.size(); i++)
      check("burst_rx_byte", rx_log[i], exp_burst[i]);
    @(negedge clk); Reg_Sel = 2'b10; #1;
    check("burst_ovr_set", Data_Out, 32'hC);
    mmio_write(2'b11, 32'h0000_0001, 1);
    @(negedge clk); Reg_Sel = 2'b10; #1;
    check("ovr_cleared", Data_Out, 32'h4);

    // Reset at cycle 40 of a frame with a byte still queued
    rx_log.delete();
    mmio_write(2'b01, 32'h0000_0000, 1);
    mmio_write(2'b01, 32'h0000_005A, 1);
    guard = 0;
    while (!tx_busy && guard < 20) begin @(negedge clk); guard++; end
    repeat (37) @(negedge clk);
    check("pre_reset_tx_low", tx, 1'b0);
    reset = 1'b0;
    #1;
    check("reset_tx_high", tx, 1'b1);
    check("reset_busy_low", tx_busy, 1'b0);
    repeat (3) @(negedge clk);
    reset = 1'b1;
    Reg_Sel = 2'b10; #1;
    check("post_reset_status", Data_Out, 32'h4);
    repeat (300) @(negedge clk);
    check("post_reset_no_frames", rx_log.size(), 0);

    // Randomized traffic against the model
    for (int it = 0; it < 150; it++) begin
      int r;
      repeat ($urandom_range(0, 30)) @(negedge clk);
      r = $urandom_range(0, 9);
      case (r)
        6:       mmio_write(2'b11, $urandom, 1);
        7:       mmio_write(2'b10, $urandom, 1);
        8:       mmio_write(2'b00, $urandom, 1);
        9:       mmio_write(2'b01, $urandom, $urandom_range(2, 6));
        default: mmio_write(2'b01, $urandom, 1);
      endcase
      if ($urandom_range(0, 1) == 1) begin
        @(negedge clk); Reg_Sel = 2'($urandom_range(0, 3));
      end
    end
    wait_idle(2000);
    check("rand_all_decoded", sent_q.size(), 0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached, %0d/%0d checks passed", n_pass, n_checks);
    $fatal(1);
  end

endmodule
